// File: rtl/pc_seq.sv
// Fetch-stage program counter with stall, start/jump loads and an optional
// circular return-address stack (compile with PC_RAS_EN to build the stack).
module pc_seq #(
  parameter int ADDR_W    = 11,
  parameter int STEP      = 1,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [2:0]                     sel_pc,
  input  logic [ADDR_W-1:0]              start_pc,
  input  logic [ADDR_W-1:0]              dp_pc,
  output logic [ADDR_W-1:0]              pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_depth,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_err
);

  localparam int DW = $clog2(RAS_DEPTH+1);

  localparam logic [2:0] SEL_INC   = 3'b000;
  localparam logic [2:0] SEL_START = 3'b001;
  localparam logic [2:0] SEL_JUMP  = 3'b011;
  localparam logic [2:0] SEL_CALL  = 3'b100;
  localparam logic [2:0] SEL_RET   = 3'b101;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;

  // Wraps modulo 2^ADDR_W; the same wrapped value is what a call pushes.
  assign pc_inc = pc + ADDR_W'(STEP);

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]     top_ptr;
  logic [PW-1:0]     top_nxt;
  logic [PW-1:0]     push_ptr;
  logic [PW-1:0]     pop_ptr;
  logic [DW-1:0]     depth_q;
  logic [DW-1:0]     depth_nxt;
  logic              err_q;
  logic              err_nxt;
  logic              push;

  // top_ptr names the most recent entry; when full, push_ptr lands on the oldest.
  assign push_ptr = (top_ptr == PW'(RAS_DEPTH-1)) ? '0 : top_ptr + PW'(1);
  assign pop_ptr  = (top_ptr == '0) ? PW'(RAS_DEPTH-1) : top_ptr - PW'(1);

  always_comb begin
    pc_nxt    = pc;
    top_nxt   = top_ptr;
    depth_nxt = depth_q;
    err_nxt   = err_q;
    push      = 1'b0;
    if (sel_pc == SEL_START) begin
      pc_nxt    = start_pc;
      top_nxt   = '0;
      depth_nxt = '0;
      err_nxt   = 1'b0;
    end else if (en) begin
      case (sel_pc)
        SEL_INC:  pc_nxt = pc_inc;
        SEL_JUMP: pc_nxt = dp_pc;
        SEL_CALL: begin
          push    = 1'b1;
          pc_nxt  = dp_pc;
          top_nxt = push_ptr;
          if (depth_q != DW'(RAS_DEPTH)) depth_nxt = depth_q + DW'(1);
        end
        SEL_RET: begin
          if (depth_q == '0) begin
            err_nxt = 1'b1;
          end else begin
            pc_nxt    = ras_mem[top_ptr];
            top_nxt   = pop_ptr;
            depth_nxt = depth_q - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_ptr <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      top_ptr <= top_nxt;
      depth_q <= depth_nxt;
      err_q   <= err_nxt;
    end
  end

  // Stack contents need no reset; occupancy is tracked by depth_q alone.
  always_ff @(posedge clk) begin
    if (push) ras_mem[push_ptr] <= pc_inc;
  end

  assign ras_depth = depth_q;
  assign ras_empty = (depth_q == '0);
  assign ras_full  = (depth_q == DW'(RAS_DEPTH));
  assign ras_err   = err_q;
`else
  always_comb begin
    pc_nxt = pc;
    if (sel_pc == SEL_START) begin
      pc_nxt = start_pc;
    end else if (en) begin
      case (sel_pc)
        SEL_INC:  pc_nxt = pc_inc;
        SEL_JUMP: pc_nxt = dp_pc;
        SEL_CALL: pc_nxt = dp_pc;
        SEL_RET:  pc_nxt = pc_inc;
        default:  ;
      endcase
    end
  end

  assign ras_depth = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= ADDR_W'(RESET_PC);
    else     pc <= pc_nxt;
  end

  assign pc_out = pc;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus random traffic,
// checked against a queue-based model of the next-PC and return-stack rules.
module tb_pc_seq;

  localparam int ADDR_W    = 11;
  localparam int STEP      = 1;
  localparam int RESET_PC  = 0;
  localparam int RAS_DEPTH = 4;
  localparam int DW        = $clog2(RAS_DEPTH+1);
  localparam int MODV      = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              en;
  logic [2:0]        sel_pc;
  logic [ADDR_W-1:0] start_pc;
  logic [ADDR_W-1:0] dp_pc;
  logic [ADDR_W-1:0] pc_out;
  logic [DW-1:0]     ras_depth;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  int tests_run;
  int tests_failed;

  // reference model state
  int m_pc;
  int m_stack[$];
  bit m_err;

  pc_seq #(
    .ADDR_W(ADDR_W), .STEP(STEP), .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sel_pc(sel_pc), .start_pc(start_pc),
    .dp_pc(dp_pc), .pc_out(pc_out), .ras_depth(ras_depth),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RESET_PC;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit e, input int sel, input int st, input int dp);
    if (sel == 1) begin
      m_pc = st;
      m_stack.delete();
      m_err = 1'b0;
    end else if (e) begin
      case (sel)
        0: m_pc = (m_pc + STEP) % MODV;
        3: m_pc = dp;
`ifdef PC_RAS_EN
        4: begin
          m_stack.push_back((m_pc + STEP) % MODV);
          if (m_stack.size() > RAS_DEPTH) void'(m_stack.pop_front());
          m_pc = dp;
        end
        5: begin
          if (m_stack.size() == 0) m_err = 1'b1;
          else m_pc = m_stack.pop_back();
        end
`else
        4: m_pc = dp;
        5: m_pc = (m_pc + STEP) % MODV;
`endif
        default: ;
      endcase
    end
  endtask

  // driver: present inputs at negedge, advance model, sample 1 ns after posedge
  task automatic drive(input bit e, input int sel, input int st, input int dp);
    @(negedge clk);
    en       = e;
    sel_pc   = 3'(sel);
    start_pc = ADDR_W'(st);
    dp_pc    = ADDR_W'(dp);
    model_step(e, sel, st, dp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sel_pc = 3'b000; start_pc = '0; dp_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (pc_out !== ADDR_W'(RESET_PC)) begin
      tests_failed++; $display("FAIL reset_pc: got %h expected %h", pc_out, ADDR_W'(RESET_PC));
    end
    tests_run++;
    if (ras_depth !== '0 || ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: depth=%0d empty=%b full=%b err=%b expected 0 1 0 0",
               ras_depth, ras_empty, ras_full, ras_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_start_seq();
    int exp_v[3] = '{'h41, 'h42, 'h43};
    drive(1, 1, 'h040, 0);
    tests_run++;
    if (pc_out !== 11'h040) begin
      tests_failed++; $display("FAIL start_load: got %h expected 040", pc_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0);
      tests_run++;
      if (pc_out !== ADDR_W'(exp_v[i]) || pc_out !== ADDR_W'(m_pc)) begin
        tests_failed++; $display("FAIL seq_inc%0d: got %h expected %h", i, pc_out, ADDR_W'(exp_v[i]));
      end
    end
  endtask

  task automatic test_stall_wrap();
    int exp_v[2] = '{'h7FF, 'h000};
    drive(1, 1, 'h7FE, 0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0);
      tests_run++;
      if (pc_out !== 11'h7FE) begin
        tests_failed++; $display("FAIL stall_hold%0d: got %h expected 7fe", i, pc_out);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0);
      tests_run++;
      if (pc_out !== ADDR_W'(exp_v[i])) begin
        tests_failed++; $display("FAIL wrap%0d: got %h expected %h", i, pc_out, ADDR_W'(exp_v[i]));
      end
    end
    drive(0, 1, 'h100, 0);
    tests_run++;
    if (pc_out !== 11'h100) begin
      tests_failed++; $display("FAIL start_while_stalled: got %h expected 100", pc_out);
    end
  endtask

  task automatic test_call_return();
    drive(1, 1, 'h010, 0);
    drive(1, 4, 0, 'h200);
    tests_run++;
    if (pc_out !== 11'h200 || ras_depth !== DW'(m_stack.size())) begin
      tests_failed++;
      $display("FAIL call1: pc=%h depth=%0d expected 200 %0d", pc_out, ras_depth, m_stack.size());
    end
`ifdef PC_RAS_EN
    drive(1, 4, 0, 'h300);
    tests_run++;
    if (pc_out !== 11'h300 || ras_depth !== DW'(2)) begin
      tests_failed++; $display("FAIL call2: pc=%h depth=%0d expected 300 2", pc_out, ras_depth);
    end
    drive(1, 5, 0, 0);
    tests_run++;
    if (pc_out !== 11'h201) begin
      tests_failed++; $display("FAIL ret1: got %h expected 201", pc_out);
    end
    drive(1, 5, 0, 0);
    tests_run++;
    if (pc_out !== 11'h011 || ras_empty !== 1'b1) begin
      tests_failed++; $display("FAIL ret2: pc=%h empty=%b expected 011 1", pc_out, ras_empty);
    end
`else
    drive(1, 5, 0, 0);
    tests_run++;
    if (pc_out !== 11'h201 || ras_err !== 1'b0 || ras_depth !== '0) begin
      tests_failed++;
      $display("FAIL ret_no_ras: pc=%h err=%b depth=%0d expected 201 0 0", pc_out, ras_err, ras_depth);
    end
`endif
  endtask

  task automatic test_overflow_underflow();
    drive(1, 1, 'h000, 0);
    for (int i = 1; i <= 5; i++) drive(1, 4, 0, i * 'h10);
    tests_run++;
    if (ras_depth !== DW'(m_stack.size()) || ras_full !== (m_stack.size() == RAS_DEPTH)) begin
      tests_failed++;
      $display("FAIL overflow_flags: depth=%0d full=%b expected %0d %b", ras_depth, ras_full,
               m_stack.size(), m_stack.size() == RAS_DEPTH);
    end
`ifdef PC_RAS_EN
    begin
      int exp_v[4] = '{'h41, 'h31, 'h21, 'h11};
      for (int i = 0; i < 4; i++) begin
        drive(1, 5, 0, 0);
        tests_run++;
        if (pc_out !== ADDR_W'(exp_v[i])) begin
          tests_failed++; $display("FAIL pop%0d: got %h expected %h", i, pc_out, ADDR_W'(exp_v[i]));
        end
      end
    end
    drive(1, 5, 0, 0);
    tests_run++;
    if (pc_out !== 11'h011 || ras_err !== 1'b1 || ras_depth !== '0) begin
      tests_failed++;
      $display("FAIL underflow: pc=%h err=%b depth=%0d expected 011 1 0", pc_out, ras_err, ras_depth);
    end
    drive(1, 3, 0, 'h155);
    drive(0, 5, 0, 0);
    drive(1, 0, 0, 0);
    tests_run++;
    if (ras_err !== 1'b1) begin
      tests_failed++; $display("FAIL err_sticky: got %b expected 1", ras_err);
    end
`endif
    drive(0, 1, 'h020, 0);
    tests_run++;
    if (ras_err !== 1'b0 || pc_out !== 11'h020 || ras_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_clear: err=%b pc=%h empty=%b expected 0 020 1", ras_err, pc_out, ras_empty);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 'h0A0, 0);
    drive(1, 4, 0, 'h0B0);
    @(negedge clk);
    en = 1'b1; sel_pc = 3'b100; dp_pc = 11'h123;
    #2 rst = 1'b1;
    #1;
    model_reset();
    tests_run++;
    if (pc_out !== ADDR_W'(RESET_PC) || ras_depth !== '0 || ras_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_reset: pc=%h depth=%0d empty=%b expected %h 0 1",
               pc_out, ras_depth, ras_empty, ADDR_W'(RESET_PC));
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (pc_out !== ADDR_W'(RESET_PC) || ras_depth !== '0) begin
      tests_failed++;
      $display("FAIL reset_over_call: pc=%h depth=%0d expected %h 0", pc_out, ras_depth, ADDR_W'(RESET_PC));
    end
    @(negedge clk);
    rst = 1'b0;
    model_step(1, 4, 0, 'h123);
    @(posedge clk);
    #1;
    tests_run++;
    if (pc_out !== ADDR_W'(m_pc) || ras_depth !== DW'(m_stack.size())) begin
      tests_failed++;
      $display("FAIL post_release_call: pc=%h depth=%0d expected %h %0d",
               pc_out, ras_depth, ADDR_W'(m_pc), m_stack.size());
    end
  endtask

  task automatic test_random();
    int sel;
    bit e;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 7);
      if (sel == 1 && $urandom_range(0, 3) != 0) sel = 5;
      e = ($urandom_range(0, 3) != 0);
      drive(e, sel, $urandom_range(0, MODV-1), $urandom_range(0, MODV-1));
      tests_run++;
      if (pc_out !== ADDR_W'(m_pc) || ras_depth !== DW'(m_stack.size()) ||
          ras_empty !== (m_stack.size() == 0) || ras_full !== (m_stack.size() == RAS_DEPTH) ||
          ras_err !== m_err) begin
        tests_failed++;
        $display("FAIL random%0d sel=%0d en=%b: pc=%h depth=%0d empty=%b full=%b err=%b expected %h %0d %b %b %b",
                 i, sel, e, pc_out, ras_depth, ras_empty, ras_full, ras_err, ADDR_W'(m_pc),
                 m_stack.size(), m_stack.size() == 0, m_stack.size() == RAS_DEPTH, m_err);
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_start_seq();
    test_stall_wrap();
    test_call_return();
    test_overflow_underflow();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the ARM32 core fetch stage. It holds the fetch address, advances it by a configurable step, and loads a start address or a datapath-supplied target. It adds stall support and an optional return-address stack, so call/return flow can be resolved without a datapath round-trip. It drives the instruction-memory address and replaces the fixed-width 11-bit PC.

## Interface
Parameters:
- ADDR_W, 11, width of every address port and of the PC register
- STEP, 1, increment applied on sequential advance
- RESET_PC, 0, value of pc_out after reset
- RAS_DEPTH, 4, return-address stack entries (≥2)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  advance enable; 0 = stall (hold) for all sel_pc codes except 3'b001
- sel_pc  in  3  next-PC select (see Operation)
- start_pc  in  ADDR_W  start address for sel_pc=3'b001
- dp_pc  in  ADDR_W  datapath branch/call target
- pc_out  out  ADDR_W  current fetch address (registered)
- ras_depth  out  $clog2(RAS_DEPTH+1)  occupied stack entries
- ras_empty  out  1  ras_depth==0
- ras_full  out  1  ras_depth==RAS_DEPTH
- ras_err  out  1  sticky flag: return popped on empty stack

## Operation
- Next-PC select, evaluated at each posedge:
  - 000: pc+STEP
  - 001: start_pc; also clears the stack and ras_err; ignores en
  - 011: dp_pc (jump)
  - 100: call; push pc+STEP, load dp_pc
  - 101: return; pop top, load it into pc
  - 010/110/111: hold
- en=0: pc, stack and flags hold; the only exception is 001.
- Arithmetic: pc+STEP is computed modulo 2^ADDR_W and wraps silently. Pushed return addresses use the same wrapped value.
- Stack:
  - Circular buffer with a top pointer and a depth counter.
  - Push when full overwrites the oldest entry; ras_depth stays RAS_DEPTH.
  - Pop when empty: pc holds its value, ras_depth stays 0, ras_err sets. ras_err is cleared only by rst or sel_pc=001.
- Only one stack operation can occur per cycle, because sel_pc is one-hot in meaning. The stack has no simultaneous push/pop case.

## Timing
- All state updates on the rising edge of clk; pc_out reflects a selection one cycle after it is presented.
- Latency: 1 cycle for every path, including pop; the stack top is read combinationally and registered into pc.
- Reset (async assert, sync-safe release):
  - pc_out=RESET_PC
  - ras_depth=0, ras_empty=1, ras_full=0, ras_err=0
  - stack contents don't-care
- Reset asserted mid-operation overrides any sel_pc/en in the same cycle. The first post-release edge acts on the sel_pc present at that edge.
- ras_empty, ras_full and ras_depth are registered-state derived and valid in the same cycle as pc_out.

## Configuration
- PC_RAS_EN defined: return-address stack built as above.
- PC_RAS_EN undefined:
  - No stack storage.
  - 100 behaves as 011 (jump to dp_pc, nothing pushed).
  - 101 behaves as 000 (pc+STEP).
  - ras_depth tied 0, ras_empty tied 1, ras_full tied 0, ras_err tied 0.

## Test plan
- Reset then start: assert rst with sel_pc=000 → pc_out=0. Release, apply sel_pc=001, start_pc=0x040 → pc_out=0x040. Then 3 cycles of 000 → 0x041, 0x042, 0x043.
- Stall and wrap:
  - pc=0x7FE, en=0, sel_pc=000 for 2 cycles → pc holds at 0x7FE.
  - en=1 → 0x7FF, then 0x000 (ADDR_W=11).
  - en=0 with sel_pc=001, start_pc=0x100 → 0x100.
- Call/return (PC_RAS_EN):
  - pc=0x010, call dp_pc=0x200 → pc=0x200, ras_depth=1.
  - From 0x200, call dp_pc=0x300 → pc=0x300, ras_depth=2.
  - Return → 0x201; return → 0x011, ras_empty=1.
- Overflow/underflow (RAS_DEPTH=4):
  - 5 calls from pcs 0x00, 0x10, 0x20, 0x30, 0x40 → ras_full=1, ras_depth=4.
  - 4 returns yield 0x41, 0x31, 0x21, 0x11.
  - 5th return: pc holds, ras_err=1.
  - ras_err stays 1 until sel_pc=001 clears it.
- Async reset mid-call: assert rst between clock edges while sel_pc=100 → pc_out=RESET_PC immediately, ras_depth=0, no push recorded.
- PC_RAS_EN undefined:
  - pc=0x010, call dp_pc=0x200 → 0x200, ras_depth=0.
  - Return → 0x201, ras_err=0.
